// File: rtl/eop_sequence_detect.sv
// eop_sequence_detect
// Bit-time sequential USB end-of-packet recogniser. Once per shift_enable strobe
// it decodes the synchronised D+/D- pair and walks an SE0-run / J-run FSM. A
// legal EOP yields a one-cycle eop pulse. A malformed one yields a one-cycle
// eop_error pulse. Legal EOPs are counted in a saturating counter.
module eop_sequence_detect #(
  parameter int SE0_MIN_BITS = 2,
  parameter int SE0_MAX_BITS = 3,
  parameter int J_BITS       = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_plus,
  input  logic             d_minus,
  input  logic             shift_enable,
  input  logic             clear_count,
  output logic             eop,
  output logic             eop_error,
  output logic [1:0]       line_state,
  output logic [CNT_W-1:0] eop_count
);

  // se0 counter must hold SE0_MAX_BITS+1, j counter must hold J_BITS
  localparam int SE0_W = $clog2(SE0_MAX_BITS + 2);
  localparam int J_W   = (J_BITS < 2) ? 1 : $clog2(J_BITS + 1);

  localparam logic [SE0_W-1:0] SE0_MIN_C = SE0_W'(SE0_MIN_BITS);
  localparam logic [SE0_W-1:0] SE0_MAX_C = SE0_W'(SE0_MAX_BITS);
  localparam logic [J_W-1:0]   J_BITS_C  = J_W'(J_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  // line codes as {d_minus, d_plus}
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SE0_RUN = 2'b01,
    ST_J_RUN   = 2'b10,
    ST_ERR     = 2'b11
  } state_t;

  state_t           state_q,   state_d;
  logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [J_W-1:0]   j_cnt_q,   j_cnt_d;
  logic             eop_q,     eop_d;
  logic             err_q,     err_d;
  logic [1:0]       ls_q,      ls_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [1:0]       pair_s;
  logic [J_W-1:0]   j_next_s;

  assign pair_s   = {d_minus, d_plus};
  assign j_next_s = j_cnt_q + J_W'(1);

  // Next-state, pulse and counter logic for one bit-time strobe
  always_comb begin
    state_d   = state_q;
    se0_cnt_d = se0_cnt_q;
    j_cnt_d   = j_cnt_q;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    ls_d      = ls_q;
    cnt_d     = cnt_q;

    if (shift_enable) begin
      ls_d = pair_s;
      case (state_q)
        ST_IDLE: begin
          if (pair_s == LS_SE0) begin
            state_d   = ST_SE0_RUN;
            se0_cnt_d = SE0_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SE0_RUN: begin
          if (pair_s == LS_SE0) begin
            if (se0_cnt_q < SE0_MAX_C) begin
              se0_cnt_d = se0_cnt_q + SE0_W'(1);
            end else begin
              err_d     = 1'b1;
              state_d   = ST_ERR;
              se0_cnt_d = '0;
            end
          end else if (pair_s == LS_J) begin
            se0_cnt_d = '0;
            if (se0_cnt_q >= SE0_MIN_C) begin
              if (J_BITS == 1) begin
                eop_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_J_RUN;
                j_cnt_d = J_W'(1);
              end
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            err_d     = 1'b1;
            state_d   = ST_ERR;
            se0_cnt_d = '0;
          end
        end
        ST_J_RUN: begin
          if (pair_s == LS_J) begin
            if (j_next_s == J_BITS_C) begin
              eop_d   = 1'b1;
              state_d = ST_IDLE;
              j_cnt_d = '0;
            end else begin
              j_cnt_d = j_next_s;
            end
          end else if (pair_s == LS_SE0) begin
            // the offending SE0 starts a fresh run
            err_d     = 1'b1;
            state_d   = ST_SE0_RUN;
            se0_cnt_d = SE0_W'(1);
            j_cnt_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
            j_cnt_d = '0;
          end
        end
        ST_ERR: begin
          if (pair_s == LS_J) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          se0_cnt_d = '0;
          j_cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // clear wins over a plain hold, but an EOP in the same cycle still counts
    if (clear_count) begin
      cnt_d = eop_d ? CNT_W'(1) : '0;
    end else if (eop_d && (cnt_q != CNT_MAX_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      se0_cnt_q <= '0;
      j_cnt_q   <= '0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      ls_q      <= LS_J;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      se0_cnt_q <= se0_cnt_d;
      j_cnt_q   <= j_cnt_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
      ls_q      <= ls_d;
      cnt_q     <= cnt_d;
    end
  end

  assign eop        = eop_q;
  assign eop_error  = err_q;
  assign line_state = ls_q;
  assign eop_count  = cnt_q;

endmodule

// File: doc/eop_sequence_detect.md
# eop_sequence_detect

Sequential successor to the combinational USB end-of-packet detector. It samples the synchronised D+/D− pair once per bit time and recognises a complete EOP: a run of SE0 bits within a legal length window, followed by a programmable number of J bits. It reports a one-cycle `eop` pulse, flags malformed EOPs, tracks the current line state and keeps a saturating EOP count. It sits in the USB receiver between the input synchronisers and the receive controller, and is strobed by the bit-timing block.

## Interface
- SE0_MIN_BITS, 2, minimum SE0 bit times for a legal EOP (≥1)
- SE0_MAX_BITS, 3, maximum SE0 bit times for a legal EOP (≥ SE0_MIN_BITS)
- J_BITS, 1, consecutive J bits required after SE0 to complete the EOP (≥1)
- CNT_W, 8, width of the EOP counter
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- d_plus  in  1  synchronised D+
- d_minus  in  1  synchronised D−
- shift_enable  in  1  one-cycle bit-sample strobe; inputs are sampled only when this is high
- clear_count  in  1  synchronous clear of eop_count
- eop  out  1  one-cycle pulse when a legal EOP completes
- eop_error  out  1  one-cycle pulse when a malformed EOP is detected
- line_state  out  2  last sampled state: 00 SE0, 01 J, 10 K, 11 SE1
- eop_count  out  CNT_W  number of legal EOPs, saturating

## Operation
- Decoding (d_plus, d_minus): (0,0)=SE0, (1,0)=J, (0,1)=K, (1,1)=SE1.
- All state, counters and outputs are registered. Nothing changes on cycles where shift_enable=0, except that eop and eop_error fall and clear_count takes effect.
- line_state loads the decoded pair on every strobe.
- The FSM has states IDLE, SE0_RUN, J_RUN and ERR. se0_cnt and j_cnt are wide enough for SE0_MAX_BITS+1 and J_BITS.
- **IDLE**
  - SE0 → SE0_RUN with se0_cnt=1.
  - Anything else → stay in IDLE.
- **SE0_RUN**
  - SE0 with se0_cnt < SE0_MAX_BITS → se0_cnt+1.
  - SE0 with se0_cnt = SE0_MAX_BITS → eop_error, go to ERR.
  - J with se0_cnt ≥ SE0_MIN_BITS:
    - If J_BITS=1 → eop, go to IDLE.
    - Otherwise → J_RUN with j_cnt=1.
  - J with se0_cnt < SE0_MIN_BITS → eop_error, go to IDLE.
  - K or SE1 → eop_error, go to ERR.
- **J_RUN**
  - J → j_cnt+1. When the new value equals J_BITS → eop, go to IDLE.
  - SE0 → eop_error, go to SE0_RUN with se0_cnt=1.
  - K or SE1 → eop_error, go to ERR.
- **ERR**
  - J → IDLE.
  - Anything else → stay in ERR; no further error pulses.
- **eop_count**
  - Increments on each eop and saturates at 2^CNT_W−1.
  - When clear_count and eop occur in the same cycle, the result is 1.
  - clear_count alone → 0.
- eop and eop_error are never high in the same cycle.

## Timing
- Reset values: state IDLE, se0_cnt=0, j_cnt=0, eop=0, eop_error=0, line_state=01 (J, idle bus), eop_count=0.
- A reset asserted mid-sequence aborts the sequence with no eop and no eop_error pulse.
- Latency: a strobe sampled at clock edge N produces its eop, eop_error or line_state update visible after edge N. Pulses are high exactly one cycle (N to N+1).
- Back-to-back strobes on consecutive cycles are supported. No minimum strobe spacing is required.
- clear_count is sampled every cycle, independent of shift_enable.

## Test plan
- **Defaults, legal EOP.** Reset, then strobe J, J, SE0, SE0, J → eop pulses for 1 cycle after the 5th strobe; eop_count=1; line_state=01; eop_error never asserted.
- **SE0 too long.** SE0 ×4 then J → eop_error pulses after the 4th strobe; FSM in ERR; the J returns it to IDLE; eop_count unchanged.
- **SE0 too short and bad terminator.** Sequence SE0, J → eop_error after the 2nd strobe. Then SE0, SE0, K → eop_error after the K; line_state=10.
- **J_BITS=3 instance.** SE0, SE0, J, J, J → eop only after the 5th strobe. Separately, SE0, SE0, J, SE0, … → eop_error at the SE0, which is treated as the first SE0 of a new run.
- **Strobe gating and reset.** Toggle d_plus/d_minus with shift_enable=0 → no output or line_state change. Assert rst during SE0_RUN → next cycle state IDLE, all outputs at reset values, no pulses.
- **Counter.** CNT_W=2: 4 legal EOPs → eop_count saturates at 3. Assert clear_count on the same cycle as a 5th eop → eop_count=1. clear_count alone → 0.
